// File: rtl/registro_banderas.sv
// Status register behind the ALU flag controller: captures NZCV, result and opcode on a valid strobe,
// accumulates sticky flags, counts accepted/refused captures and evaluates condition codes.
//
//  state  | meaning
//  -------+------------------------------------------------
//  ESPERA | no capture accepted on the last edge, listo=0
//  ACK    | capture accepted on the last edge, listo=1
module registro_banderas #(
    parameter int ancho      = 3,
    parameter int ANCHO_CONT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valido,
    input  logic                  congelar,
    input  logic                  limpiar,
    input  logic                  N_in,
    input  logic                  Z_in,
    input  logic                  C_in,
    input  logic                  V_in,
    input  logic [ancho:0]        resultado_in,
    input  logic [3:0]            seleccion_in,
    input  logic [3:0]            condicion,
    output logic                  N,
    output logic                  Z,
    output logic                  C,
    output logic                  V,
    output logic [ancho:0]        resultado,
    output logic [3:0]            seleccion,
    output logic [3:0]            pegajosas,
    output logic                  cond_cumplida,
    output logic                  listo,
    output logic [ANCHO_CONT-1:0] cuenta_ops,
    output logic [ANCHO_CONT-1:0] cuenta_perdidas
);

    localparam logic [0:0] ESPERA = 1'b0;
    localparam logic [0:0] ACK    = 1'b1;

    localparam logic [ANCHO_CONT-1:0] CONT_MAX = {ANCHO_CONT{1'b1}};
    localparam logic [ANCHO_CONT-1:0] CONT_UNO = ANCHO_CONT'(1);

    logic                  acepta;
    logic                  rechaza;
    logic [3:0]            banderas_in;

    logic [3:0]            banderas_q,        banderas_d;
    logic [ancho:0]        resultado_q,       resultado_d;
    logic [3:0]            seleccion_q,       seleccion_d;
    logic [3:0]            pegajosas_q,       pegajosas_d;
    logic [0:0]            estado_q,          estado_d;
    logic [ANCHO_CONT-1:0] cuenta_ops_q,      cuenta_ops_d;
    logic [ANCHO_CONT-1:0] cuenta_perdidas_q, cuenta_perdidas_d;
    logic [ANCHO_CONT-1:0] ops_base;
    logic [ANCHO_CONT-1:0] perdidas_base;

    assign acepta      = valido & ~congelar;
    assign rechaza     = valido &  congelar;
    assign banderas_in = {N_in, Z_in, C_in, V_in};

    always_comb begin
        banderas_d  = banderas_q;
        resultado_d = resultado_q;
        seleccion_d = seleccion_q;
        if (acepta) begin
            banderas_d  = banderas_in;
            resultado_d = resultado_in;
            seleccion_d = seleccion_in;
        end
    end

    // Clear takes effect before the same-cycle capture/refusal is accumulated.
    always_comb begin
        pegajosas_d   = limpiar ? 4'b0000 : pegajosas_q;
        ops_base      = limpiar ? '0 : cuenta_ops_q;
        perdidas_base = limpiar ? '0 : cuenta_perdidas_q;

        if (acepta) begin
            pegajosas_d = pegajosas_d | banderas_in;
        end

        cuenta_ops_d = ops_base;
        if (acepta && (ops_base != CONT_MAX)) begin
            cuenta_ops_d = ops_base + CONT_UNO;
        end

        cuenta_perdidas_d = perdidas_base;
        if (rechaza && (perdidas_base != CONT_MAX)) begin
            cuenta_perdidas_d = perdidas_base + CONT_UNO;
        end
    end

    always_comb begin
        estado_d = ESPERA;
        case (estado_q)
            ESPERA:  estado_d = acepta ? ACK : ESPERA;
            ACK:     estado_d = acepta ? ACK : ESPERA;
            default: estado_d = ESPERA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            banderas_q        <= 4'b0000;
            resultado_q       <= '0;
            seleccion_q       <= 4'b0000;
            pegajosas_q       <= 4'b0000;
            estado_q          <= ESPERA;
            cuenta_ops_q      <= '0;
            cuenta_perdidas_q <= '0;
        end else begin
            banderas_q        <= banderas_d;
            resultado_q       <= resultado_d;
            seleccion_q       <= seleccion_d;
            pegajosas_q       <= pegajosas_d;
            estado_q          <= estado_d;
            cuenta_ops_q      <= cuenta_ops_d;
            cuenta_perdidas_q <= cuenta_perdidas_d;
        end
    end

    assign N               = banderas_q[3];
    assign Z               = banderas_q[2];
    assign C               = banderas_q[1];
    assign V               = banderas_q[0];
    assign resultado       = resultado_q;
    assign seleccion       = seleccion_q;
    assign pegajosas       = pegajosas_q;
    assign listo           = (estado_q == ACK);
    assign cuenta_ops      = cuenta_ops_q;
    assign cuenta_perdidas = cuenta_perdidas_q;

    // Condition evaluation works on stored flags only, so it is stable between captures.
    always_comb begin
        cond_cumplida = 1'b0;
        case (condicion)
            4'b0000: cond_cumplida = Z;
            4'b0001: cond_cumplida = ~Z;
            4'b0010: cond_cumplida = C;
            4'b0011: cond_cumplida = ~C;
            4'b0100: cond_cumplida = N;
            4'b0101: cond_cumplida = ~N;
            4'b0110: cond_cumplida = V;
            4'b0111: cond_cumplida = ~V;
            4'b1000: cond_cumplida = C & ~Z;
            4'b1001: cond_cumplida = ~C | Z;
            4'b1010: cond_cumplida = (N == V);
            4'b1011: cond_cumplida = (N != V);
            4'b1100: cond_cumplida = ~Z & (N == V);
            4'b1101: cond_cumplida = Z | (N != V);
            4'b1110: cond_cumplida = 1'b1;
            default: cond_cumplida = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_registro_banderas.sv
// Bench for registro_banderas: directed vector table, hand-written saturation sequence,
// then random traffic against a behavioural model; two instances cover 8-bit and 2-bit counters.
module tb_registro_banderas;

    logic       clk = 1'b0;
    logic       rst, valido, congelar, limpiar;
    logic       N_in, Z_in, C_in, V_in;
    logic [3:0] resultado_in, seleccion_in, condicion;

    logic       N, Z, C, V, cond_cumplida, listo;
    logic [3:0] resultado, seleccion, pegajosas;
    logic [7:0] cuenta_ops, cuenta_perdidas;

    logic       s_N, s_Z, s_C, s_V, s_cond, s_listo;
    logic [3:0] s_resultado, s_seleccion, s_pegajosas;
    logic [1:0] s_ops, s_perdidas;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    registro_banderas #(.ancho(3), .ANCHO_CONT(8)) dut (
        .clk(clk), .rst(rst), .valido(valido), .congelar(congelar), .limpiar(limpiar),
        .N_in(N_in), .Z_in(Z_in), .C_in(C_in), .V_in(V_in),
        .resultado_in(resultado_in), .seleccion_in(seleccion_in), .condicion(condicion),
        .N(N), .Z(Z), .C(C), .V(V), .resultado(resultado), .seleccion(seleccion),
        .pegajosas(pegajosas), .cond_cumplida(cond_cumplida), .listo(listo),
        .cuenta_ops(cuenta_ops), .cuenta_perdidas(cuenta_perdidas)
    );

    registro_banderas #(.ancho(3), .ANCHO_CONT(2)) dut_sat (
        .clk(clk), .rst(rst), .valido(valido), .congelar(congelar), .limpiar(limpiar),
        .N_in(N_in), .Z_in(Z_in), .C_in(C_in), .V_in(V_in),
        .resultado_in(resultado_in), .seleccion_in(seleccion_in), .condicion(condicion),
        .N(s_N), .Z(s_Z), .C(s_C), .V(s_V), .resultado(s_resultado), .seleccion(s_seleccion),
        .pegajosas(s_pegajosas), .cond_cumplida(s_cond), .listo(s_listo),
        .cuenta_ops(s_ops), .cuenta_perdidas(s_perdidas)
    );

    typedef struct {
        bit       rst, val, cong, lim;
        bit [3:0] nzcv, res, sel, cond;
        bit [3:0] e_nzcv, e_res, e_sel, e_peg;
        bit       e_listo;
        int       e_ops, e_lost;
        bit       e_cc;
    } vec_t;

    vec_t tabla[$];

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive(input bit r, input bit v, input bit cg, input bit l,
                         input bit [3:0] f, input bit [3:0] rs, input bit [3:0] sl, input bit [3:0] cd);
        rst = r; valido = v; congelar = cg; limpiar = l;
        {N_in, Z_in, C_in, V_in} = f;
        resultado_in = rs; seleccion_in = sl; condicion = cd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit r, bit v, bit cg, bit l, bit [3:0] f, bit [3:0] rs, bit [3:0] sl,
                                bit [3:0] cd, bit [3:0] en, bit [3:0] er, bit [3:0] es, bit [3:0] ep,
                                bit el, int eo, int elo, bit ec);
        vec_t t;
        t.rst = r; t.val = v; t.cong = cg; t.lim = l; t.nzcv = f; t.res = rs; t.sel = sl; t.cond = cd;
        t.e_nzcv = en; t.e_res = er; t.e_sel = es; t.e_peg = ep;
        t.e_listo = el; t.e_ops = eo; t.e_lost = elo; t.e_cc = ec;
        return t;
    endfunction

    // Behavioural reference: condition codes evaluated from their meaning on integer flags.
    function automatic bit cond_ref(bit [3:0] f, bit [3:0] cd);
        int n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cd)
            0: return z == 1;        1: return z == 0;
            2: return c == 1;        3: return c == 0;
            4: return n == 1;        5: return n == 0;
            6: return v == 1;        7: return v == 0;
            8: return c == 1 && z == 0;
            9: return c == 0 || z == 1;
            10: return n == v;       11: return n != v;
            12: return z == 0 && n == v;
            13: return z == 1 || n != v;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    bit [3:0] m_nzcv, m_res, m_sel, m_peg;
    bit       m_listo;
    int       m_ops, m_lost, m_ops_s, m_lost_s;

    function automatic int sat_inc(int x, int maxv);
        return (x >= maxv) ? maxv : x + 1;
    endfunction

    task automatic model_step(bit r, bit v, bit cg, bit l, bit [3:0] f, bit [3:0] rs, bit [3:0] sl);
        if (r) begin
            m_nzcv = 0; m_res = 0; m_sel = 0; m_peg = 0; m_listo = 0;
            m_ops = 0; m_lost = 0; m_ops_s = 0; m_lost_s = 0;
        end else begin
            if (l) begin
                m_peg = 0; m_ops = 0; m_lost = 0; m_ops_s = 0; m_lost_s = 0;
            end
            m_listo = v && !cg;
            if (v && !cg) begin
                m_nzcv = f; m_res = rs; m_sel = sl; m_peg = m_peg | f;
                m_ops = sat_inc(m_ops, 255); m_ops_s = sat_inc(m_ops_s, 3);
            end
            if (v && cg) begin
                m_lost = sat_inc(m_lost, 255); m_lost_s = sat_inc(m_lost_s, 3);
            end
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        //            rst v cg l  nzcv     res  sel  cond   | nzcv    res  sel  peg     li ops lost cc
        tabla.push_back(mk(1, 1, 0, 0, 4'b1000, 4'd0, 4'd0, 4'b1110, 4'b0000, 4'd0, 4'd0, 4'b0000, 0, 0, 0, 1));
        tabla.push_back(mk(1, 1, 0, 0, 4'b1000, 4'd0, 4'd0, 4'b0000, 4'b0000, 4'd0, 4'd0, 4'b0000, 0, 0, 0, 0));
        tabla.push_back(mk(0, 1, 0, 0, 4'b0100, 4'd0, 4'd1, 4'b0000, 4'b0100, 4'd0, 4'd1, 4'b0100, 1, 1, 0, 1));
        tabla.push_back(mk(0, 0, 0, 1, 4'b0000, 4'd0, 4'd0, 4'b0001, 4'b0100, 4'd0, 4'd1, 4'b0000, 0, 0, 0, 0));
        tabla.push_back(mk(0, 1, 0, 0, 4'b1000, 4'd5, 4'd2, 4'b0100, 4'b1000, 4'd5, 4'd2, 4'b1000, 1, 1, 0, 1));
        tabla.push_back(mk(0, 1, 0, 0, 4'b0010, 4'd6, 4'd3, 4'b0010, 4'b0010, 4'd6, 4'd3, 4'b1010, 1, 2, 0, 1));
        tabla.push_back(mk(0, 1, 0, 0, 4'b0001, 4'd7, 4'd4, 4'b1011, 4'b0001, 4'd7, 4'd4, 4'b1011, 1, 3, 0, 1));
        tabla.push_back(mk(0, 1, 1, 0, 4'b1111, 4'd15, 4'd15, 4'b0110, 4'b0001, 4'd7, 4'd4, 4'b1011, 0, 3, 1, 1));
        tabla.push_back(mk(0, 1, 1, 0, 4'b1111, 4'd15, 4'd15, 4'b0111, 4'b0001, 4'd7, 4'd4, 4'b1011, 0, 3, 2, 0));
        tabla.push_back(mk(0, 1, 0, 1, 4'b0100, 4'd9, 4'd8, 4'b1100, 4'b0100, 4'd9, 4'd8, 4'b0100, 1, 1, 0, 0));
        tabla.push_back(mk(0, 1, 1, 1, 4'b1111, 4'd2, 4'd2, 4'b1101, 4'b0100, 4'd9, 4'd8, 4'b0000, 0, 0, 1, 1));
        tabla.push_back(mk(1, 1, 0, 0, 4'b1111, 4'd3, 4'd3, 4'b1111, 4'b0000, 4'd0, 4'd0, 4'b0000, 0, 0, 0, 0));
        tabla.push_back(mk(0, 1, 0, 0, 4'b0010, 4'd3, 4'd1, 4'b1000, 4'b0010, 4'd3, 4'd1, 4'b0010, 1, 1, 0, 1));
        tabla.push_back(mk(0, 0, 0, 0, 4'b1111, 4'd0, 4'd0, 4'b1001, 4'b0010, 4'd3, 4'd1, 4'b0010, 0, 1, 0, 0));
        tabla.push_back(mk(0, 0, 0, 0, 4'b0000, 4'd0, 4'd0, 4'b1010, 4'b0010, 4'd3, 4'd1, 4'b0010, 0, 1, 0, 1));
        tabla.push_back(mk(0, 0, 0, 0, 4'b0000, 4'd0, 4'd0, 4'b0011, 4'b0010, 4'd3, 4'd1, 4'b0010, 0, 1, 0, 0));
        tabla.push_back(mk(0, 0, 0, 0, 4'b0000, 4'd0, 4'd0, 4'b0101, 4'b0010, 4'd3, 4'd1, 4'b0010, 0, 1, 0, 1));

        for (int i = 0; i < tabla.size(); i++) begin
            vec_t t;
            t = tabla[i];
            drive(t.rst, t.val, t.cong, t.lim, t.nzcv, t.res, t.sel, t.cond);
            tick();
            check($sformatf("vec%0d nzcv", i), {N, Z, C, V}, t.e_nzcv);
            check($sformatf("vec%0d resultado", i), resultado, t.e_res);
            check($sformatf("vec%0d seleccion", i), seleccion, t.e_sel);
            check($sformatf("vec%0d pegajosas", i), pegajosas, t.e_peg);
            check($sformatf("vec%0d listo", i), listo, t.e_listo);
            check($sformatf("vec%0d cuenta_ops", i), cuenta_ops, t.e_ops);
            check($sformatf("vec%0d cuenta_perdidas", i), cuenta_perdidas, t.e_lost);
            check($sformatf("vec%0d cond_cumplida", i), cond_cumplida, t.e_cc);
        end

        // Counter saturation: 2-bit counters stick at 3, 8-bit keep counting.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int k = 1; k <= 5; k++) begin
            drive(0, 1, 0, 0, 4'b0001, 4'(k), 4'(k), 4'b1110);
            tick();
            check($sformatf("sat ops2 #%0d", k), s_ops, (k > 3) ? 3 : k);
            check($sformatf("sat ops8 #%0d", k), cuenta_ops, k);
            check($sformatf("sat listo #%0d", k), s_listo, 1);
        end
        for (int k = 1; k <= 5; k++) begin
            drive(0, 1, 1, 0, 4'b1111, 0, 0, 4'b1110);
            tick();
            check($sformatf("sat lost2 #%0d", k), s_perdidas, (k > 3) ? 3 : k);
            check($sformatf("sat lost8 #%0d", k), cuenta_perdidas, k);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("sat listo drop", s_listo, 0);

        // Random traffic against the model, both instances.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 600; k++) begin
            bit r, v, cg, l;
            bit [3:0] f, rs, sl, cd;
            r  = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 1) == 1);
            cg = ($urandom_range(0, 3) == 0);
            l  = ($urandom_range(0, 9) == 0);
            f  = 4'($urandom); rs = 4'($urandom); sl = 4'($urandom); cd = 4'($urandom);
            drive(r, v, cg, l, f, rs, sl, cd);
            model_step(r, v, cg, l, f, rs, sl);
            tick();
            check("rnd nzcv", {N, Z, C, V}, m_nzcv);
            check("rnd resultado", resultado, m_res);
            check("rnd seleccion", seleccion, m_sel);
            check("rnd pegajosas", pegajosas, m_peg);
            check("rnd listo", listo, m_listo);
            check("rnd cuenta_ops", cuenta_ops, m_ops);
            check("rnd cuenta_perdidas", cuenta_perdidas, m_lost);
            check("rnd cond_cumplida", cond_cumplida, cond_ref(m_nzcv, cd));
            check("rnd sat ops", s_ops, m_ops_s);
            check("rnd sat perdidas", s_perdidas, m_lost_s);
            check("rnd sat nzcv", {s_N, s_Z, s_C, s_V}, m_nzcv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
